// File: rtl/control_types_pkg.sv
// Shared control types for the EX stage.
// Contents:
//   XLEN     - integer datapath width (RV32I: 32)
//   alu_op_t - ALU operation select, 4-bit encoding shared with decode
package control_types_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_XOR = 4'd3,
        ALU_OR  = 4'd4,
        ALU_AND = 4'd5,
        ALU_SL  = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8,
        ALU_LT  = 4'd9,
        ALU_LTU = 4'd10,
        ALU_LUI = 4'd11
    } alu_op_t;

endpackage

// File: rtl/riscv_alu.sv
// RV32I integer ALU for the EX stage.
// The result is combinational (zero latency) for forwarding and branch/address
// use. A registered copy of the result is also provided for pipeline/debug use.
// Ports:
//   clk        - system clock (only used by result_q)
//   rst_n      - asynchronous active-low reset (only clears result_q)
//   operand_a  - first operand (rs1 or PC)
//   operand_b  - second operand (rs2 or immediate)
//   alu_op     - operation select
//   result     - combinational result
//   zero       - combinational flag, high when result == 0
//   result_q   - result registered on rising clk
module riscv_alu
    import control_types_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  alu_op_t         alu_op,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [XLEN-1:0] result_q
);

    // Only the low 5 bits of operand_b select the shift distance.
    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    assign shamt       = operand_b[4:0];
    assign lt_signed   = $signed(operand_a) < $signed(operand_b);
    assign lt_unsigned = operand_a < operand_b;

    // Default of zero keeps NOP and unlisted encodings independent of the
    // operands, so X on a/b cannot leak into the result.
    always_comb begin
        result = '0;
        unique case (alu_op)
            ALU_ADD: result = operand_a + operand_b;
            ALU_SUB: result = operand_a - operand_b;
            ALU_XOR: result = operand_a ^ operand_b;
            ALU_OR:  result = operand_a | operand_b;
            ALU_AND: result = operand_a & operand_b;
            ALU_SL:  result = operand_a << shamt;
            ALU_SRL: result = operand_a >> shamt;
            ALU_SRA: result = $unsigned($signed(operand_a) >>> shamt);
            ALU_LT:  result = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_LTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_LUI: result = operand_b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result;
        end
    end

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed combinational operations plus
// the registered result path including asynchronous reset behaviour.
module tb_riscv_alu;
    import control_types_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    alu_op_t     alu_op;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;

    int unsigned n_checks;
    int unsigned n_fails;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    riscv_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .alu_op    (alu_op),
        .result    (result),
        .zero      (zero),
        .result_q  (result_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one operation, queue its expected result, then pop and compare
    // once the combinational output has settled.
    task automatic apply(input string tag, input alu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] e;
        string       t;
        operand_a = a;
        operand_b = b;
        alu_op    = op;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check32(t, result, e);
        check1({t, "_zero"}, zero, (e == 32'h0));
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        operand_a = '0;
        operand_b = '0;
        alu_op    = ALU_NOP;

        // Reset state before any clock edge.
        #1;
        check32("reset_no_clock", result_q, 32'h0);

        // Arithmetic
        apply("add_5_10",     ALU_ADD, 32'd5,          32'd10,         32'd15);
        apply("sub_5_10",     ALU_SUB, 32'd5,          32'd10,         32'hFFFF_FFFB);
        apply("add_wrap",     ALU_ADD, 32'hFFFF_FFFF,  32'd1,          32'h0);
        apply("sub_wrap",     ALU_SUB, 32'h0,          32'd1,          32'hFFFF_FFFF);
        // Logic
        apply("and",          ALU_AND, 32'hF0,         32'h0F,         32'h00);
        apply("or",           ALU_OR,  32'hF0,         32'h0F,         32'hFF);
        apply("xor",          ALU_XOR, 32'hF0,         32'hFF,         32'h0F);
        // Shifts
        apply("sl_2_3",       ALU_SL,  32'd2,          32'd3,          32'd16);
        apply("srl_80_4",     ALU_SRL, 32'h80,         32'd4,          32'h8);
        apply("sra_neg_4",    ALU_SRA, 32'hFFFF_FF80,  32'd4,          32'hFFFF_FFF8);
        apply("sra_pos_4",    ALU_SRA, 32'h7FFF_FF80,  32'd4,          32'h07FF_FFF8);
        apply("srl_neg_4",    ALU_SRL, 32'hFFFF_FF80,  32'd4,          32'h0FFF_FFF8);
        apply("sl_hi_bits",   ALU_SL,  32'd1,          32'h23,         32'd8);
        apply("sl_by_0",      ALU_SL,  32'h1234_5678,  32'h20,         32'h1234_5678);
        apply("sra_by_0",     ALU_SRA, 32'h8765_4321,  32'h0,          32'h8765_4321);
        apply("sl_by_31",     ALU_SL,  32'h3,          32'd31,         32'h8000_0000);
        apply("srl_by_31",    ALU_SRL, 32'h8000_0000,  32'd31,         32'h1);
        apply("sra_by_31",    ALU_SRA, 32'h8000_0000,  32'd31,         32'hFFFF_FFFF);
        // Compares
        apply("lt_neg_pos",   ALU_LT,  32'hFFFF_FFFF,  32'd5,          32'd1);
        apply("lt_pos_neg",   ALU_LT,  32'd5,          32'hFFFF_FFFF,  32'd0);
        apply("ltu_big_small",ALU_LTU, 32'hFFFF_FFFF,  32'd5,          32'd0);
        apply("ltu_small_big",ALU_LTU, 32'd5,          32'hFFFF_FFFF,  32'd1);
        apply("lt_equal",     ALU_LT,  32'd7,          32'd7,          32'd0);
        apply("ltu_equal",    ALU_LTU, 32'd7,          32'd7,          32'd0);
        // Pass-through / NOP / undefined
        apply("lui",          ALU_LUI, 'x,             32'hABCD_E000,  32'hABCD_E000);
        apply("nop_x",        ALU_NOP, 'x,             'x,             32'h0);
        apply("undef_15",     alu_op_t'(4'd15), 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);
        apply("undef_12",     alu_op_t'(4'd12), 32'h5,  32'h3,         32'h0);

        // Register path: reset must hold result_q through an edge.
        apply("reg_setup",    ALU_ADD, 32'd40,         32'd2,          32'd42);
        @(posedge clk); #1;
        check32("reset_holds_over_edge", result_q, 32'h0);

        // Release reset away from the edge, then load ADD(1,2).
        @(negedge clk);
        rst_n = 1'b1;
        apply("reg_add_comb", ALU_ADD, 32'd1,          32'd2,          32'd3);
        exp_q.push_back(32'd3);
        @(posedge clk); #1;
        check32("result_q_load", result_q, exp_q.pop_front());

        // Next edge loads the new result.
        apply("reg_sub_comb", ALU_SUB, 32'd5,          32'd10,         32'hFFFF_FFFB);
        exp_q.push_back(32'hFFFF_FFFB);
        @(posedge clk); #1;
        check32("result_q_load2", result_q, exp_q.pop_front());

        // Async reset mid-cycle clears without waiting for an edge.
        #2;
        rst_n = 1'b0;
        #1;
        check32("async_reset_mid_cycle", result_q, 32'h0);

        // Deassert mid-stream; loading resumes on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        apply("reg_xor_comb", ALU_XOR, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555);
        #1;
        check32("no_load_before_edge", result_q, 32'h0);
        exp_q.push_back(32'h5555_5555);
        @(posedge clk); #1;
        check32("result_q_resume", result_q, exp_q.pop_front());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
